mcs_fpro_bridge: RTL
====================

# mcs_fpro_bridge

Parametrised bridge between the MicroBlaze MCS IO bus and the FPro bus, the successor to the fixed two-region bridge. It supports N_REGION chip-select regions, a configurable slave read latency, byte-enable forwarding, and an error response for out-of-window or malformed accesses, so the CPU can never hang. It sits in each top level between the `cpu` instance and the mmio/video subsystems.

## Interface
Parameters:
- BRG_BASE, 32'hc000_0000, bridge window base; only bits [31:24] are compared.
- N_REGION, 2, number of FPro regions; power of two, 2..8. RW = $clog2(N_REGION).
- RD_LAT, 1, cycles from fp_rd to valid fp_rd_data; range 0..3.
- ADDR_W, 22-RW (derived, not overridable), FPro word-address width; 21 at the defaults.

Ports:
- clk  in  1  system clock. One clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_addr_strobe / io_read_strobe / io_write_strobe  in  1 each  MCS request strobes.
- io_address  in  32  byte address.
- io_byte_enable  in  4  byte lanes.
- io_write_data  in  32  write data.
- io_read_data  out  32  read response.
- io_ready  out  1  one-cycle completion pulse.
- fp_cs  out  N_REGION  one-hot region select.
- fp_wr, fp_rd  out  1 each  single-cycle strobes.
- fp_be  out  4  forwarded byte enables.
- fp_addr  out  ADDR_W  word address, io_address[23-RW:2].
- fp_wr_data  out  32  forwarded write data.
- fp_rd_data  in  N_REGION×32 (packed [N_REGION-1:0][31:0])  per-region read data.
- err_clr  in  1  clears the sticky error.
- bus_err  out  1  sticky error flag.
- err_addr  out  32  io_address of the first error since the last clear.

## Operation
- Window hit: io_address[31:24] == BRG_BASE[31:24]. Region index r = io_address[23 -: RW].
- FSM states:
  - IDLE → ISSUE on a valid request: io_addr_strobe with exactly one of io_read_strobe/io_write_strobe, in window. The request is latched.
  - IDLE → RESP_ERR on a strobe that is out of window, or has both or neither direction strobes.
  - ISSUE lasts one cycle. fp_cs[r]=1 and fp_wr or fp_rd=1; fp_addr, fp_be and fp_wr_data are driven from the latched values.
  - From ISSUE, a write goes to RESP. A read goes to RESP when RD_LAT==0, otherwise to WAIT.
  - WAIT counts down RD_LAT-1..0, then goes to RESP.
  - Read data is fp_rd_data[r], sampled on the last cycle before RESP (ISSUE when RD_LAT==0).
  - RESP: io_ready=1 and io_read_data = captured data (32'h0 for writes). Next state is IDLE.
  - RESP_ERR: io_ready=1 and io_read_data=32'hDEAD_BEEF. It sets bus_err and captures err_addr if bus_err was clear. Next state is IDLE.
- A strobe arriving in any non-IDLE state is ignored for transfer purposes. It sets bus_err and captures err_addr if bus_err was clear. The request in progress still completes normally.
- err_clr clears bus_err. If err_clr and a new error occur in the same cycle, the error wins: bus_err stays 1 and err_addr takes the new address.
- fp_cs, fp_wr and fp_rd are zero in every state except ISSUE.
- fp_addr, fp_be and fp_wr_data hold their last values outside ISSUE.

## Timing
- Strobe sampled at cycle 0.
  - Write: fp_wr at cycle 1, io_ready at cycle 2.
  - Read: fp_rd at cycle 1, data sampled at cycle 1+RD_LAT, io_ready at cycle 2+RD_LAT.
  - Error: io_ready at cycle 1.
- Back-to-back: a new strobe is accepted in the cycle after io_ready, i.e. the first IDLE cycle.
- Reset values: all outputs 0, state IDLE, bus_err=0, err_addr=0.
- Reset asserted mid-transaction aborts it. No io_ready is produced, and fp_* drop to 0 asynchronously.

## Structure
- Package `fpro_bus_pkg`:
  - state enum `brg_state_t` (IDLE, ISSUE, WAIT, RESP, RESP_ERR)
  - constant `FP_ERR_DATA` = 32'hDEAD_BEEF
  - function `fp_addr_w(n_region)`
- One sub-module, `fpro_region_dec`: combinational window-hit and one-hot region decode, parametrised by N_REGION and BRG_BASE.
- The FSM, latency counter and error registers live in the top module.

## Test plan
- Write, defaults: io_address=32'hC000_0010, data 32'h1234_5678, be=4'hF → cycle 1 has fp_cs=2'b01, fp_wr=1, fp_addr=4; io_ready at cycle 2 with io_read_data=0.
- Read, RD_LAT=2, N_REGION=4: address 32'hC040_0008, fp_rd_data[1]=32'hA5A5_0001 → fp_cs=4'b0010 at cycle 1; io_ready at cycle 4 with io_read_data=32'hA5A5_0001.
- Out of window: read at 32'h8000_0000 → io_ready at cycle 1 with 32'hDEAD_BEEF; bus_err=1, err_addr=32'h8000_0000. Pulsing err_clr returns bus_err to 0.
- Both direction strobes with address 32'hC000_0004 → error response; no fp_wr or fp_rd pulse; err_addr=32'hC000_0004.
- Strobe during WAIT (RD_LAT=3): the original read still completes with correct data; bus_err=1; exactly one fp_rd pulse is seen.
- Reset pulled low during WAIT → io_ready never asserts, all outputs 0; after release a write completes normally in 2 cycles.

Source files
------------

// File: rtl/fpro_bus_pkg.sv
// fpro_bus_pkg
//   Shared types and constants for the MCS-to-FPro bridge.
//   brg_state_t : bridge FSM state encoding
//   FP_ERR_DATA : read data returned with an error response
//   fp_addr_w() : FPro word-address width for a given region count
package fpro_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        RESP_ERR
    } brg_state_t;

    localparam logic [31:0] FP_ERR_DATA = 32'hDEAD_BEEF;

    // The region index takes the top bits of the 24-bit window offset,
    // leaving 22 - log2(n_region) bits of word address.
    function automatic int unsigned fp_addr_w(input int unsigned n_region);
        int unsigned rw;
        rw = 0;
        for (int unsigned i = 1; i <= 3; i++) begin
            if ((32'd1 << (i - 1)) < n_region) rw = i;
        end
        return 22 - rw;
    endfunction

endpackage

// File: rtl/fpro_region_dec.sv
// fpro_region_dec
//   Combinational window-hit and one-hot region decode.
//   addr_i : io_address[31:24-RW] (window byte plus region index bits)
//   hit_o  : address falls inside the bridge window
//   idx_o  : binary region index
//   sel_o  : one-hot region select
module fpro_region_dec #(
    parameter int unsigned  N_REGION = 2,
    parameter logic [31:0]  BRG_BASE = 32'hc000_0000,
    localparam int unsigned RW       = $clog2(N_REGION)
) (
    input  logic [7+RW:0]       addr_i,
    output logic                hit_o,
    output logic [RW-1:0]       idx_o,
    output logic [N_REGION-1:0] sel_o
);

    assign hit_o = (addr_i[7+RW -: 8] == BRG_BASE[31:24]);
    assign idx_o = addr_i[RW-1:0];

    always_comb begin
        sel_o        = '0;
        sel_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/mcs_fpro_bridge.sv
// mcs_fpro_bridge
//   Bridge from the MicroBlaze MCS IO bus to the FPro bus with N_REGION
//   chip-select regions, configurable read latency and error responses.
//   clk, reset_n                     : clock, async active-low reset
//   io_addr/read/write_strobe        : MCS request strobes
//   io_address, io_byte_enable       : byte address, byte lanes
//   io_write_data / io_read_data     : MCS data in / response data out
//   io_ready                         : one-cycle completion pulse
//   fp_cs, fp_wr, fp_rd              : FPro select and strobes (ISSUE only)
//   fp_be, fp_addr, fp_wr_data       : FPro request fields (held)
//   fp_rd_data                       : per-region read data
//   err_clr, bus_err, err_addr       : sticky error flag and first address
module mcs_fpro_bridge
    import fpro_bus_pkg::*;
#(
    parameter logic [31:0]  BRG_BASE = 32'hc000_0000,
    parameter int unsigned  N_REGION = 2,
    parameter int unsigned  RD_LAT   = 1,
    localparam int unsigned RW       = $clog2(N_REGION),
    localparam int unsigned ADDR_W   = fp_addr_w(N_REGION)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      io_addr_strobe,
    input  logic                      io_read_strobe,
    input  logic                      io_write_strobe,
    input  logic [31:0]               io_address,
    input  logic [3:0]                io_byte_enable,
    input  logic [31:0]               io_write_data,
    output logic [31:0]               io_read_data,
    output logic                      io_ready,
    output logic [N_REGION-1:0]       fp_cs,
    output logic                      fp_wr,
    output logic                      fp_rd,
    output logic [3:0]                fp_be,
    output logic [ADDR_W-1:0]         fp_addr,
    output logic [31:0]               fp_wr_data,
    input  logic [N_REGION-1:0][31:0] fp_rd_data,
    input  logic                      err_clr,
    output logic                      bus_err,
    output logic [31:0]               err_addr
);

    brg_state_t          state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                is_wr_q;
    logic [RW-1:0]       idx_q;
    logic [N_REGION-1:0] cs_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                bus_err_q;
    logic [31:0]         err_addr_q;

    logic                dec_hit;
    logic [RW-1:0]       dec_idx;
    logic [N_REGION-1:0] dec_sel;
    logic                req_ok;
    logic                accept;
    logic                sample;
    logic                err_evt;

    fpro_region_dec #(
        .N_REGION (N_REGION),
        .BRG_BASE (BRG_BASE)
    ) u_dec (
        .addr_i (io_address[31:24-RW]),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .sel_o  (dec_sel)
    );

    assign req_ok = io_addr_strobe && (io_read_strobe ^ io_write_strobe) && dec_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        sample       = 1'b0;
        err_evt      = 1'b0;
        fp_cs        = '0;
        fp_wr        = 1'b0;
        fp_rd        = 1'b0;
        io_ready     = 1'b0;
        io_read_data = '0;
        case (state_q)
            IDLE: begin
                if (io_addr_strobe) begin
                    if (req_ok) begin
                        accept  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        err_evt = 1'b1;
                        state_d = RESP_ERR;
                    end
                end
            end
            ISSUE: begin
                fp_cs = cs_q;
                fp_wr = is_wr_q;
                fp_rd = !is_wr_q;
                if (is_wr_q) begin
                    state_d = RESP;
                end else if (RD_LAT == 0) begin
                    sample  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    sample  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                io_ready     = 1'b1;
                io_read_data = rdata_q;
                state_d      = IDLE;
            end
            RESP_ERR: begin
                io_ready     = 1'b1;
                io_read_data = FP_ERR_DATA;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A strobe while busy is flagged but never disturbs the transfer.
        if (state_q != IDLE && io_addr_strobe) err_evt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_wr_q    <= 1'b0;
            idx_q      <= '0;
            cs_q       <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (accept) begin
                is_wr_q <= io_write_strobe;
                idx_q   <= dec_idx;
                cs_q    <= dec_sel;
                addr_q  <= io_address[23-RW:2];
                be_q    <= io_byte_enable;
                wdata_q <= io_write_data;
                rdata_q <= '0;
            end
            if (sample) rdata_q <= fp_rd_data[idx_q];
            // A new error outranks a simultaneous clear, so it re-captures.
            if (err_evt) begin
                bus_err_q <= 1'b1;
                if (!bus_err_q || err_clr) err_addr_q <= io_address;
            end else if (err_clr) begin
                bus_err_q <= 1'b0;
            end
        end
    end

    assign fp_addr    = addr_q;
    assign fp_be      = be_q;
    assign fp_wr_data = wdata_q;
    assign bus_err    = bus_err_q;
    assign err_addr   = err_addr_q;

endmodule
